bitmap_alloc64: RTL
===================

# bitmap_alloc64

Bitmap allocator for a 64-entry resource pool, such as physical registers, ROB-side tags or load/store queue slots. It holds a 64-bit free bitmap and offers the lowest-numbered free entry every cycle, using a trailing-zero count over the bitmap. It also accepts returned entries, decoding each index back into a single bitmap bit. It is the writer and owner of the bitmap whose trailing-zero count selects the next grant.

## Interface
- `N` — default 64; entry count, fixed at 64 in this revision.
- `W` — default 6; index width, equal to log2(`N`).
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `flush`  in  1  — synchronous; returns every entry to free.
- `alloc_req`  in  1  — consumer takes `alloc_idx` this cycle.
- `alloc_valid`  out  1  — registered; at least one entry is free.
- `alloc_idx`  out  `W`  — registered; lowest free index.
- `free_valid`  in  1  — return one entry this cycle.
- `free_idx`  in  `W`  — index being returned.
- `free_count`  out  `W`+1  — registered; number of free entries, 0..64.
- `free_err`  out  1  — sticky; a free was attempted on an already-free entry.

## Operation
- State:
  - `bitmap[63:0]`: 1 means free.
  - Registered copies of `alloc_valid`, `alloc_idx` and `free_count`.
  - `free_err`.
- Reset (async) and `flush` (sync) load the same state:
  - `bitmap` = all ones, `alloc_valid` = 1, `alloc_idx` = 0, `free_count` = 64.
  - Reset also sets `free_err` = 0. `flush` leaves `free_err` unchanged.
- `alloc_fire` = `alloc_req` & `alloc_valid`. When `alloc_valid` = 0, `alloc_req` is ignored and causes no state change and no error.
- `free_ok` = `free_valid` & !`bitmap[free_idx]`, i.e. the entry is currently busy.
- Double free: `free_valid` & `bitmap[free_idx]` sets `free_err`; `bitmap` and `free_count` are unaffected by that free.
- Next bitmap: `bmp_n` = (`bitmap` & ~(`alloc_fire` ? onehot(`alloc_idx`) : 0)) | (`free_ok` ? onehot(`free_idx`) : 0).
- Priority:
  - `flush` overrides `alloc_fire` and `free_ok` in the same cycle.
  - Between alloc and free there is no conflict: a free never targets the entry being allocated, because that entry is free in `bitmap`, so such a free is a double free.
- Registered outputs update from `bmp_n`:
  - `alloc_valid` <= |`bmp_n`.
  - `alloc_idx` <= ctz(`bmp_n`) truncated to 6 bits, or 0 when `bmp_n` = 0.
  - `free_count` <= `free_count` − `alloc_fire` + `free_ok`. Arithmetic is at `W`+1 bits and can never wrap, given the guards above.
- Invariant: `free_count` == popcount(`bitmap`). The bench checks this every cycle.

## Timing
- The offer is registered, so there is no combinational path from any input to any output.
- Alloc-to-next-offer latency is 1 cycle: after a fire in cycle t, `alloc_idx` in t+1 is the next-lowest free entry. Back-to-back allocation every cycle is sustained.
- Free-to-visible latency is 1 cycle: an entry freed in t is offered in t+1 if it is the lowest free entry, and counted in `free_count` at t+1.
- Simultaneous fire of index j and free of index k < j in cycle t gives `alloc_idx` = k at t+1 and `free_count` unchanged.
- Full pool (`free_count` = 0): `alloc_valid` = 0 and `alloc_idx` = 0. A free in t makes `alloc_valid` = 1 at t+1.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously). The first allocation is possible in the first cycle after deassertion.

## Test plan
- Reset, then hold `alloc_req` = 1 for 64 cycles → `alloc_idx` = 0,1,…,63 in consecutive cycles. At cycle 65: `alloc_valid` = 0, `free_count` = 0.
- From full, free 37 then 5 on consecutive cycles → `alloc_idx` = 37 then 5, `free_count` = 1 then 2. Then allocate twice → indices 5 then 37.
- With 0..9 busy (offer = 10), free 3 and fire in the same cycle → next `alloc_idx` = 3, `free_count` unchanged, bit 10 busy.
- Free 50 while bit 50 is free → `free_err` = 1 and stays 1. `free_count` and `alloc_idx` are unchanged. `flush` does not clear `free_err`; only reset does.
- With 20 entries busy, assert `flush` together with `alloc_req` and a legal free → next cycle `free_count` = 64, `alloc_idx` = 0, all bits free.
- Random alloc/free/flush for 100k cycles against a reference model → `alloc_idx` equals the lowest free index, popcount invariant holds, and no index is granted twice without an intervening free. Include an asynchronous reset pulse mid-run and check immediate reset values.

Source files
------------

// File: rtl/bitmap_alloc64.sv
// Bitmap allocator for a 64-entry pool: offers the lowest free index every cycle
// from a registered trailing-zero count, and takes returned entries back into the bitmap.
module bitmap_alloc64 #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         alloc_req,
  output logic         alloc_valid,
  output logic [W-1:0] alloc_idx,
  input  logic         free_valid,
  input  logic [W-1:0] free_idx,
  output logic [W:0]   free_count,
  output logic         free_err
);

  // Handshake: alloc_valid/alloc_idx are an offer; an entry is consumed only in a
  // cycle where alloc_req and alloc_valid are both high (alloc_fire). alloc_req
  // while alloc_valid is low is a no-op. free_valid is unconditionally accepted.

  logic [N-1:0] bitmap;
  logic [N-1:0] bmp_n;
  logic         alloc_fire;
  logic         free_hit;
  logic         free_ok;

  // Lowest set bit of v, or 0 when v is empty.
  function automatic logic [W-1:0] ctz(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  always_comb begin
    alloc_fire = alloc_req & alloc_valid;
    free_hit   = bitmap[free_idx];
    free_ok    = free_valid & ~free_hit;
    bmp_n      = bitmap;
    if (alloc_fire) bmp_n[alloc_idx] = 1'b0;
    // A legal free can never hit the offered entry, since that entry is already free.
    if (free_ok) bmp_n[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap      <= '1;
      alloc_valid <= 1'b1;
      alloc_idx   <= '0;
      free_count  <= (W+1)'(N);
      free_err    <= 1'b0;
    end else begin
      if (free_valid & free_hit) free_err <= 1'b1;
      if (flush) begin
        bitmap      <= '1;
        alloc_valid <= 1'b1;
        alloc_idx   <= '0;
        free_count  <= (W+1)'(N);
      end else begin
        bitmap      <= bmp_n;
        alloc_valid <= |bmp_n;
        alloc_idx   <= ctz(bmp_n);
        free_count  <= free_count - (W+1)'(alloc_fire) + (W+1)'(free_ok);
      end
    end
  end

endmodule
